// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
// Receives a framed byte stream (16-bit word count, big-endian payload words,
// XOR checksum), writes each assembled word into instruction memory and holds
// the core in reset until a complete, verified frame has been loaded.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        core_reset,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        CNT_HI = 3'd0,
        CNT_LO = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [15:0]       n_r;
    logic [ADDR_W:0]   word_idx_r;
    logic [1:0]        byte_cnt_r;
    logic [23:0]       word_r;
    logic [7:0]        csum_r;
    logic [31:0]       mem_addr_r;
    logic [31:0]       mem_wdata_r;

    logic              consume_s;
    logic [15:0]       n_full_s;
    logic              oversize_s;
    logic              zero_s;
    logic              last_word_s;
    logic              csum_ok_s;

    // Running payload checksum: plain XOR fold of every payload byte.
    function automatic logic [7:0] csum_next(input logic [7:0] csum, input logic [7:0] data);
        csum_next = csum ^ data;
    endfunction

    assign consume_s   = rx_valid & rx_ready;
    // Full count as it will be once the low count byte is latched.
    assign n_full_s    = {n_r[15:8], rx_data};
    // Exactly 2^ADDR_W words is legal; anything above cannot fit.
    assign oversize_s  = ({1'b0, n_full_s} > (17'd1 << ADDR_W));
    assign zero_s      = (n_full_s == 16'd0);
    // word_idx_r is compared before its increment in WRITE.
    assign last_word_s = (({{(15 - ADDR_W){1'b0}}, word_idx_r} + 16'd1) == n_r);
    assign csum_ok_s   = (rx_data == csum_r);

    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= CNT_HI;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic for the frame parser.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            CNT_HI: begin
                if (consume_s) begin
                    state_next_s = CNT_LO;
                end else begin
                    state_next_s = CNT_HI;
                end
            end
            CNT_LO: begin
                if (!consume_s) begin
                    state_next_s = CNT_LO;
                end else if (oversize_s) begin
                    state_next_s = ERROR;
                end else if (zero_s) begin
                    state_next_s = CHECK;
                end else begin
                    state_next_s = DATA;
                end
            end
            DATA: begin
                if (consume_s && (byte_cnt_r == 2'd3)) begin
                    state_next_s = WRITE;
                end else begin
                    state_next_s = DATA;
                end
            end
            WRITE: begin
                if (last_word_s) begin
                    state_next_s = CHECK;
                end else begin
                    state_next_s = DATA;
                end
            end
            CHECK: begin
                if (!consume_s) begin
                    state_next_s = CHECK;
                end else if (csum_ok_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = ERROR;
                end
            end
            DONE:    state_next_s = DONE;
            ERROR:   state_next_s = ERROR;
            // An illegal encoding keeps the core held in reset.
            default: state_next_s = ERROR;
        endcase
    end

    // Output decode from the registered state; rx_ready is forced low during reset.
    always_comb begin
        rx_ready   = 1'b0;
        mem_we     = 1'b0;
        core_reset = 1'b1;
        done       = 1'b0;
        err        = 1'b0;
        if (reset) begin
            rx_ready = 1'b0;
        end else begin
            case (state_r)
                CNT_HI, CNT_LO, DATA, CHECK: rx_ready = 1'b1;
                WRITE:   mem_we = 1'b1;
                DONE: begin
                    core_reset = 1'b0;
                    done       = 1'b1;
                end
                ERROR:   err = 1'b1;
                default: err = 1'b1;
            endcase
        end
    end

    // Datapath: word count, byte assembly, checksum, write address/data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_r         <= 16'd0;
            word_idx_r  <= '0;
            byte_cnt_r  <= 2'd0;
            word_r      <= 24'd0;
            csum_r      <= 8'd0;
            mem_addr_r  <= 32'd0;
            mem_wdata_r <= 32'd0;
        end else begin
            case (state_r)
                CNT_HI: begin
                    if (consume_s) begin
                        n_r[15:8] <= rx_data;
                    end
                end
                CNT_LO: begin
                    if (consume_s) begin
                        n_r[7:0]   <= rx_data;
                        word_idx_r <= '0;
                        byte_cnt_r <= 2'd0;
                    end
                end
                DATA: begin
                    if (consume_s) begin
                        word_r     <= {word_r[15:0], rx_data};
                        csum_r     <= csum_next(csum_r, rx_data);
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            mem_addr_r  <= {{(30 - ADDR_W){1'b0}}, word_idx_r[ADDR_W-1:0], 2'b00};
                            mem_wdata_r <= {word_r, rx_data};
                        end
                    end
                end
                WRITE: begin
                    word_idx_r <= word_idx_r + {{ADDR_W{1'b0}}, 1'b1};
                end
                default: begin
                    n_r <= n_r;
                end
            endcase
        end
    end

endmodule
